// File: rtl/counter_preload_sched.sv
// Preload scheduler for the 4-bit loadable counter: buffers preload values in a
// FIFO and replays the head into the counter at each wrap point (or on force).
module counter_preload_sched #(
  parameter int unsigned DEPTH = 4,
  parameter logic [3:0]  MATCH = 4'hF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  input  logic [3:0]                 req_data,
  output logic                       req_ready,
  input  logic                       force_load,
  input  logic [3:0]                 count_in,
  output logic                       load,
  output logic [3:0]                 load_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       miss,
  input  logic                       miss_clr,
  output logic [7:0]                 loads_done
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DEPTH-1:0][3:0] mem;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  empty, full, at_match, push, pop;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign at_match = (count_in == MATCH);

  // Ready comes from the registered level only, so there is no path from load.
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign load      = !empty && (at_match || force_load);
  assign pop       = load;
  assign load_data = empty ? 4'h0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      miss       <= 1'b0;
      loads_done <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level      <= level + LW'(push) - LW'(pop);
      loads_done <= loads_done + 8'(pop);
      // A wrap point with nothing to load outranks a clear in the same cycle.
      if (empty && at_match) miss <= 1'b1;
      else if (miss_clr)     miss <= 1'b0;
    end
  end
endmodule
